// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, latched op kinds, op decode.
package mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_resp_state_t;
  typedef enum logic [1:0] {READ, WRITE, BAD} mem_op_t;

  localparam int CNT_W = 4;

  // Read and write together is malformed and completes as an error.
  function automatic mem_op_t decode_op(input logic rd, input logic wr);
    if (rd && wr) return BAD;
    if (wr)       return WRITE;
    return READ;
  endfunction

endpackage

// File: rtl/sram_bytewr.sv
// Single-port word memory with byte-enabled synchronous write and registered read.
module sram_bytewr #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [AW-1:0]        addr,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < WIDTH/8; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, waits LATENCY cycles, then
// completes with a one-cycle mem_resp pulse, flagging range and op errors.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_resp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t          op_q, op_d;
  logic             err_q, err_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  logic [29:0] word_off;
  logic        in_range;
  logic [31:0] sram_rdata;
  logic        sram_we;

  // Full 32-bit compare so addresses below the base never wrap into range.
  assign word_off = mem_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (mem_addr >= BASE_ADDR) && (word_off < 30'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          op_d    = decode_op(mem_read, mem_write);
          err_d   = (op_d == BAD) || !in_range;
          idx_d   = word_off[AW-1:0];
          wdata_d = mem_wdata;
          be_d    = mem_be;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= READ;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Commit only on the edge ending a clean write RESP; reset at that edge aborts it.
  assign sram_we = (state_q == RESP) && (op_q == WRITE) && !err_q && !rst;

  sram_bytewr #(.WIDTH(32), .DEPTH(DEPTH_WORDS)) u_sram (
    .clk    (clk),
    .addr   (idx_d),
    .we     (sram_we),
    .be     (be_q),
    .wdata  (wdata_q),
    .rdata_q(sram_rdata)
  );

  assign mem_resp  = (state_q == RESP);
  assign mem_err   = mem_resp && err_q;
  assign mem_rdata = (mem_resp && (op_q == READ) && !err_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table at LATENCY=2 plus latency sweep and reset abort.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp, mem_err;
  logic [3:0]  mem_be;

  logic [31:0]       s_addr;
  logic              s_read;
  logic [2:0]        s_resp, s_err;
  logic [2:0][31:0]  s_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h1000), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 15;
    mem_responder #(.LATENCY(L)) u_sw (
      .clk(clk), .rst(rst), .mem_addr(s_addr), .mem_wdata(32'h0),
      .mem_read(s_read), .mem_write(1'b0), .mem_be(4'h0),
      .mem_rdata(s_rdata[g]), .mem_resp(s_resp[g]), .mem_err(s_err[g])
    );
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic cur_resp(input int k);
    return (k < 0) ? mem_resp : s_resp[k];
  endfunction

  // Called #1 after an edge with the request already driven; lat counts the
  // acceptance edge as 1, so lat == LATENCY when the pulse lands on time.
  task automatic wait_resp(input int k, output int lat);
    @(posedge clk); #1;
    lat = 1;
    while (!cur_resp(k) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_txn(input string nm, input vec_t v);
    int lat;
    mem_read = v.rd; mem_write = v.wr; mem_addr = v.addr;
    mem_wdata = v.wdata; mem_be = v.be;
    wait_resp(-1, lat);
    chk($sformatf("%s lat", nm), 32'(lat), 32'd2);
    chk($sformatf("%s rdata", nm), mem_rdata, v.exp_rd);
    chk($sformatf("%s err", nm), {31'b0, mem_err}, {31'b0, v.exp_err});
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s pulse_end", nm), {31'b0, mem_resp}, 32'd0);
    chk($sformatf("%s idle_out", nm), {mem_rdata[30:0] | {30'b0, mem_err}}, 32'd0);
  endtask

  initial begin
    int lat;
    int exp_lat[3];
    vec_t rv;
    exp_lat = '{1, 3, 15};

    vecs[0]  = '{1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1008, 32'h00AA0000, 4'h4, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h1008, 32'h0,        4'h0, 32'h11AA3344, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0FFC, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h5000, 32'hAAAAAAAA, 4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h4FFC, 32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h1004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h1006, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,    4'h0, 32'h0,        1'b1};

    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    s_read = 1'b0; s_addr = 32'h1000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp", {31'b0, mem_resp}, 32'd0);
    chk("reset err", {31'b0, mem_err}, 32'd0);
    chk("reset rdata", mem_rdata, 32'd0);
    chk("reset cnt", 32'(u_dut.cnt_q), 32'd0);

    u_dut.u_sram.mem[0]    = 32'hCAFEF00D;
    u_dut.u_sram.mem[2]    = 32'h11223344;
    u_dut.u_sram.mem[4]    = 32'h0BADBEEF;
    u_dut.u_sram.mem[4095] = 32'h12345678;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset during RESP of a write must abort the commit.
    mem_write = 1'b1; mem_addr = 32'h1010; mem_wdata = 32'h55; mem_be = 4'hF;
    wait_resp(-1, lat);
    chk("rstwr reached_resp", {31'b0, mem_resp}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstwr resp_after", {31'b0, mem_resp}, 32'd0);
    chk("rstwr rdata_after", mem_rdata, 32'd0);
    rst = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    rv = '{1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, 32'h0BADBEEF, 1'b0};
    run_txn("rstwr readback", rv);

    // Latency sweep with the request held across RESP: re-accepted in the next IDLE cycle.
    for (int k = 0; k < 3; k++) begin
      s_read = 1'b1;
      wait_resp(k, lat);
      chk($sformatf("sweep%0d lat", exp_lat[k]), 32'(lat), 32'(exp_lat[k]));
      chk($sformatf("sweep%0d err", exp_lat[k]), {31'b0, s_err[k]}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("sweep%0d width", exp_lat[k]), {31'b0, s_resp[k]}, 32'd0);
      wait_resp(k, lat);
      chk($sformatf("sweep%0d relat", exp_lat[k]), 32'(lat), 32'(exp_lat[k]));
      s_read = 1'b0;
      repeat (20) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
